// File: rtl/hsv_core_pkg.sv
// Shared types for the ScaleCore-V memory unit: metadata and result records,
// access sizes, exception cause codes and the pending-counter width.
package hsv_core_pkg;

    localparam int MEM_PENDING_DEPTH = 8;
    localparam int TOKEN_W           = 4;

    typedef logic [31:0] word;
    typedef logic [$clog2(MEM_PENDING_DEPTH + 1)-1:0] mem_counter;

    typedef enum logic [1:0] {
        BYTE = 2'd0,
        HALF = 2'd1,
        WORD = 2'd2
    } mem_size_t;

    typedef enum logic {
        DIR_READ  = 1'b0,
        DIR_WRITE = 1'b1
    } mem_dir_t;

    typedef logic [3:0] exc_cause_t;

    localparam exc_cause_t EXC_LOAD_MISALIGNED  = 4'd4;
    localparam exc_cause_t EXC_LOAD_FAULT       = 4'd5;
    localparam exc_cause_t EXC_STORE_MISALIGNED = 4'd6;
    localparam exc_cause_t EXC_STORE_FAULT      = 4'd7;

    // One entry per memory instruction, issued in program order.
    typedef struct packed {
        logic [TOKEN_W-1:0] token;
        mem_dir_t           dir;
        mem_size_t          size;
        logic               is_unsigned;
        logic [1:0]         addr;
        logic               misaligned;
        logic               fence;
    } mem_meta_t;

    typedef struct packed {
        logic [TOKEN_W-1:0] token;
        word                data;
        logic               exception;
        exc_cause_t         cause;
    } mem_result_t;

endpackage

// File: rtl/hsv_core_mem_load_align.sv
// Load data formatting: moves the addressed byte lane down to bit 0, keeps
// only the access size and sign- or zero-extends to a full word.
module hsv_core_mem_load_align
    import hsv_core_pkg::*;
(
    input  word        data,
    input  mem_size_t  size,
    input  logic [1:0] addr,
    input  logic       is_unsigned,
    output word        result
);

    word  shifted;
    logic sign;

    // Lane shift followed by truncation and extension.
    always_comb begin
        shifted = data >> {addr, 3'b000};
        sign    = 1'b0;
        result  = shifted;
        case (size)
            BYTE: begin
                sign   = ~is_unsigned & shifted[7];
                result = {{24{sign}}, shifted[7:0]};
            end
            HALF: begin
                sign   = ~is_unsigned & shifted[15];
                result = {{16{sign}}, shifted[15:0]};
            end
            default: result = shifted;
        endcase
    end

endmodule

// File: rtl/hsv_core_mem_response.sv
// Memory unit response stage: matches R/B beats to the in-order metadata
// stream, formats load data, retires pending counters and registers one
// result toward commit. After a flush it drains outstanding AXI responses.
module hsv_core_mem_response
    import hsv_core_pkg::*;
#(
    parameter int PENDING_FIFO_DEPTH = MEM_PENDING_DEPTH
) (
    input  logic        clk_core,
    input  logic        rst_core_n,
    input  logic        flush,

    input  mem_meta_t   meta_i,
    input  logic        meta_valid_i,
    output logic        meta_ready_o,

    input  logic        dmem_r_valid,
    output logic        dmem_r_ready,
    input  word         dmem_r_data,
    input  logic [1:0]  dmem_r_resp,

    input  logic        dmem_b_valid,
    output logic        dmem_b_ready,
    input  logic [1:0]  dmem_b_resp,

    input  mem_counter  pending_reads,
    input  mem_counter  pending_writes,
    output logic        pending_reads_down,
    output logic        pending_writes_down,

    output logic        fence_ready,

    output logic        valid_o,
    input  logic        stall_i,
    output mem_result_t result_o
);

    // The counter type must be able to hold the full FIFO depth.
    if ($clog2(PENDING_FIFO_DEPTH + 1) > $bits(mem_counter)) begin : g_depth_check
        $error("mem_counter too narrow for PENDING_FIFO_DEPTH");
    end

    typedef enum logic {RUN, DRAIN} state_t;

    state_t      state;
    logic        active;      // low until the first edge after reset, keeps readies quiet
    logic        out_free;
    logic        head_mis, head_fence, head_rd, head_wr;
    logic        r_hs, b_hs;
    logic        reads_zero, writes_zero, drained;
    logic        take, emit;
    word         load_data;
    mem_result_t res;
    logic        resp_unused;

    // Only the slave-error bit of the AXI response matters here.
    assign resp_unused = ^{dmem_r_resp[0], dmem_b_resp[0]};

    assign out_free    = ~valid_o | ~stall_i;
    assign fence_ready = (pending_reads == '0) & (pending_writes == '0) & ~valid_o;

    // Classify the head entry; misaligned wins over fence, fence over direction.
    always_comb begin
        head_mis   = meta_valid_i & meta_i.misaligned;
        head_fence = meta_valid_i & ~meta_i.misaligned & meta_i.fence;
        head_rd    = meta_valid_i & ~meta_i.misaligned & ~meta_i.fence & (meta_i.dir == DIR_READ);
        head_wr    = meta_valid_i & ~meta_i.misaligned & ~meta_i.fence & (meta_i.dir == DIR_WRITE);
    end

    // Channel readies never look at dmem_*_valid, so no AXI valid->ready path.
    always_comb begin
        dmem_r_ready = 1'b0;
        dmem_b_ready = 1'b0;
        if (active) begin
            if (state == DRAIN) begin
                dmem_r_ready = 1'b1;
                dmem_b_ready = 1'b1;
            end else begin
                dmem_r_ready = head_rd & out_free;
                dmem_b_ready = head_wr & out_free;
            end
        end
    end

    assign r_hs                = dmem_r_valid & dmem_r_ready;
    assign b_hs                = dmem_b_valid & dmem_b_ready;
    assign pending_reads_down  = r_hs;
    assign pending_writes_down = b_hs;

    // A count that is about to retire its last entry this cycle already counts as empty.
    assign reads_zero  = (pending_reads == '0) | ((pending_reads == mem_counter'(1)) & r_hs);
    assign writes_zero = (pending_writes == '0) | ((pending_writes == mem_counter'(1)) & b_hs);
    assign drained     = reads_zero & writes_zero;

    // The head entry completes this cycle; a flush still lets the beat retire
    // but suppresses the pop and the result.
    assign take = active & (state == RUN) &
                  ((head_mis & out_free) |
                   (head_fence & fence_ready & out_free) |
                   (head_rd & r_hs) |
                   (head_wr & b_hs));
    assign meta_ready_o = take & ~flush;
    assign emit         = meta_ready_o;

    hsv_core_mem_load_align u_load_align (
        .data        (dmem_r_data),
        .size        (meta_i.size),
        .addr        (meta_i.addr),
        .is_unsigned (meta_i.is_unsigned),
        .result      (load_data)
    );

    // Result record for the head entry.
    always_comb begin
        res       = '0;
        res.token = meta_i.token;
        if (head_mis) begin
            res.exception = 1'b1;
            res.cause     = (meta_i.dir == DIR_WRITE) ? EXC_STORE_MISALIGNED : EXC_LOAD_MISALIGNED;
        end else if (head_rd) begin
            if (dmem_r_resp[1]) begin
                res.exception = 1'b1;
                res.cause     = EXC_LOAD_FAULT;
            end else begin
                res.data = load_data;
            end
        end else if (head_wr) begin
            if (dmem_b_resp[1]) begin
                res.exception = 1'b1;
                res.cause     = EXC_STORE_FAULT;
            end
        end
    end

    // RUN/DRAIN state and the registered result port.
    always_ff @(posedge clk_core or negedge rst_core_n) begin
        if (!rst_core_n) begin
            state    <= RUN;
            active   <= 1'b0;
            valid_o  <= 1'b0;
            result_o <= '0;
        end else begin
            active <= 1'b1;
            case (state)
                RUN:     if (flush && !drained) state <= DRAIN;
                DRAIN:   if (!flush && drained) state <= RUN;
                default: state <= RUN;
            endcase
            if (emit) begin
                valid_o  <= 1'b1;
                result_o <= res;
            end else if (flush || !stall_i) begin
                valid_o  <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_hsv_core_mem_response.sv
// Self-checking bench for hsv_core_mem_response: directed scenarios plus a
// randomized program-order stream checked against a behavioural model.
module tb_hsv_core_mem_response;
    import hsv_core_pkg::*;

    logic        clk_core = 1'b0;
    logic        rst_core_n = 1'b0;
    logic        flush;
    mem_meta_t   meta_i;
    logic        meta_valid_i, meta_ready_o;
    logic        dmem_r_valid, dmem_r_ready;
    word         dmem_r_data;
    logic [1:0]  dmem_r_resp;
    logic        dmem_b_valid, dmem_b_ready;
    logic [1:0]  dmem_b_resp;
    mem_counter  pending_reads, pending_writes;
    logic        pending_reads_down, pending_writes_down;
    logic        fence_ready;
    logic        valid_o, stall_i;
    mem_result_t result_o;

    int checks = 0;
    int errors = 0;

    always #5 clk_core = ~clk_core;

    hsv_core_mem_response #(.PENDING_FIFO_DEPTH(8)) dut (
        .clk_core(clk_core), .rst_core_n(rst_core_n), .flush(flush),
        .meta_i(meta_i), .meta_valid_i(meta_valid_i), .meta_ready_o(meta_ready_o),
        .dmem_r_valid(dmem_r_valid), .dmem_r_ready(dmem_r_ready),
        .dmem_r_data(dmem_r_data), .dmem_r_resp(dmem_r_resp),
        .dmem_b_valid(dmem_b_valid), .dmem_b_ready(dmem_b_ready), .dmem_b_resp(dmem_b_resp),
        .pending_reads(pending_reads), .pending_writes(pending_writes),
        .pending_reads_down(pending_reads_down), .pending_writes_down(pending_writes_down),
        .fence_ready(fence_ready), .valid_o(valid_o), .stall_i(stall_i), .result_o(result_o)
    );

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    // ---------------- behavioural reference ----------------
    function automatic mem_meta_t mk_meta(int tok, mem_dir_t dir, mem_size_t sz, logic uns,
                                          int a, logic mis, logic fen);
        mem_meta_t m;
        m.token = TOKEN_W'(tok);
        m.dir = dir;
        m.size = sz;
        m.is_unsigned = uns;
        m.addr = 2'(a);
        m.misaligned = mis;
        m.fence = fen;
        return m;
    endfunction

    // Load value from plain arithmetic: divide down to the lane, keep the size, fix the sign.
    function automatic word model_load(word d, mem_size_t sz, logic [1:0] a, logic uns);
        int unsigned x, div;
        div = 1;
        for (int k = 0; k < int'(a); k++) div = div * 256;
        x = d / div;
        if (sz == BYTE) begin
            x = x % 256;
            if (!uns && x >= 128) x = x - 256;
        end else if (sz == HALF) begin
            x = x % 65536;
            if (!uns && x >= 32768) x = x - 65536;
        end
        return word'(x);
    endfunction

    function automatic mem_result_t model_result(mem_meta_t m, word d, logic [1:0] resp);
        mem_result_t r;
        r = '0;
        r.token = m.token;
        if (m.misaligned) begin
            r.exception = 1'b1;
            r.cause = (m.dir == DIR_WRITE) ? EXC_STORE_MISALIGNED : EXC_LOAD_MISALIGNED;
        end else if (m.fence) begin
            r.data = '0;
        end else if (m.dir == DIR_READ) begin
            if (resp == 2'b10 || resp == 2'b11) begin
                r.exception = 1'b1;
                r.cause = EXC_LOAD_FAULT;
            end else begin
                r.data = model_load(d, m.size, m.addr, m.is_unsigned);
            end
        end else if (resp == 2'b10 || resp == 2'b11) begin
            r.exception = 1'b1;
            r.cause = EXC_STORE_FAULT;
        end
        return r;
    endfunction

    task automatic idle_inputs();
        flush = 1'b0; meta_valid_i = 1'b0; meta_i = '0;
        dmem_r_valid = 1'b0; dmem_r_data = '0; dmem_r_resp = 2'b00;
        dmem_b_valid = 1'b0; dmem_b_resp = 2'b00; stall_i = 1'b0;
    endtask

    task automatic step();
        @(posedge clk_core);
        #1;
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        idle_inputs();
        pending_reads = '0; pending_writes = '0;
        meta_valid_i = 1'b1; meta_i = mk_meta(1, DIR_READ, WORD, 1'b0, 0, 1'b0, 1'b0);
        dmem_r_valid = 1'b1; dmem_b_valid = 1'b1;
        @(negedge clk_core);
        checks++;
        if ({valid_o, meta_ready_o, dmem_r_ready, dmem_b_ready, pending_reads_down, pending_writes_down} !== 6'b0) begin
            errors++;
            $display("FAIL reset_ctrl: got %b want 000000",
                     {valid_o, meta_ready_o, dmem_r_ready, dmem_b_ready, pending_reads_down, pending_writes_down});
        end
        checks++;
        if (result_o !== '0) begin
            errors++; $display("FAIL reset_result: got %h want 0", result_o);
        end
        idle_inputs();
        rst_core_n = 1'b1;
        step(); step();
    endtask

    // LB signed, LHU, SW with SLVERR, misaligned load.
    task automatic test_load_format();
        mem_meta_t   m[4];
        word         d[4];
        logic [1:0]  rs[4];
        int          kind[4];   // 0 read, 1 write, 2 no beat
        mem_result_t exp[4];
        m[0] = mk_meta(1, DIR_READ,  BYTE, 1'b0, 3, 1'b0, 1'b0); d[0] = 32'h80AA_BBCC; rs[0] = 2'b00; kind[0] = 0;
        m[1] = mk_meta(2, DIR_READ,  HALF, 1'b1, 2, 1'b0, 1'b0); d[1] = 32'h8001_1234; rs[1] = 2'b00; kind[1] = 0;
        m[2] = mk_meta(3, DIR_WRITE, WORD, 1'b0, 0, 1'b0, 1'b0); d[2] = '0;           rs[2] = 2'b10; kind[2] = 1;
        m[3] = mk_meta(4, DIR_READ,  WORD, 1'b0, 1, 1'b1, 1'b0); d[3] = '0;           rs[3] = 2'b00; kind[3] = 2;
        exp[0] = '{token: 4'd1, data: 32'hFFFF_FF80, exception: 1'b0, cause: 4'd0};
        exp[1] = '{token: 4'd2, data: 32'h0000_8001, exception: 1'b0, cause: 4'd0};
        exp[2] = '{token: 4'd3, data: 32'h0, exception: 1'b1, cause: EXC_STORE_FAULT};
        exp[3] = '{token: 4'd4, data: 32'h0, exception: 1'b1, cause: EXC_LOAD_MISALIGNED};
        for (int i = 0; i < 4; i++) begin
            idle_inputs();
            meta_valid_i = 1'b1; meta_i = m[i];
            if (kind[i] == 0) begin dmem_r_valid = 1'b1; dmem_r_data = d[i]; dmem_r_resp = rs[i]; end
            if (kind[i] == 1) begin dmem_b_valid = 1'b1; dmem_b_resp = rs[i]; end
            @(negedge clk_core);
            checks++;
            if ({meta_ready_o, pending_reads_down, pending_writes_down} !==
                {1'b1, kind[i] == 0, kind[i] == 1}) begin
                errors++;
                $display("FAIL fmt_handshake[%0d]: got %b want %b", i,
                         {meta_ready_o, pending_reads_down, pending_writes_down},
                         {1'b1, kind[i] == 0, kind[i] == 1});
            end
            step();
            idle_inputs();
            @(negedge clk_core);
            checks++;
            if (valid_o !== 1'b1 || result_o !== exp[i] || pending_reads_down !== 1'b0) begin
                errors++;
                $display("FAIL fmt_result[%0d]: got v=%b res=%h down=%b want v=1 res=%h down=0",
                         i, valid_o, result_o, pending_reads_down, exp[i]);
            end
            step();
        end
    endtask

    // Head is a write while an R beat is already waiting.
    task automatic test_order();
        mem_result_t ew, er;
        idle_inputs();
        meta_valid_i = 1'b1; meta_i = mk_meta(5, DIR_WRITE, WORD, 1'b0, 0, 1'b0, 1'b0);
        dmem_r_valid = 1'b1; dmem_r_data = 32'h1234_5678;
        for (int c = 0; c < 2; c++) begin
            @(negedge clk_core);
            checks++;
            if (dmem_r_ready !== 1'b0 || dmem_b_ready !== 1'b1) begin
                errors++;
                $display("FAIL order_wait[%0d]: got r_ready=%b b_ready=%b want 0 1", c, dmem_r_ready, dmem_b_ready);
            end
            step();
        end
        dmem_b_valid = 1'b1;
        @(negedge clk_core);
        checks++;
        if ({pending_reads_down, pending_writes_down} !== 2'b01) begin
            errors++; $display("FAIL order_b_down: got %b want 01", {pending_reads_down, pending_writes_down});
        end
        step();
        dmem_b_valid = 1'b0;
        meta_i = mk_meta(6, DIR_READ, WORD, 1'b0, 0, 1'b0, 1'b0);
        ew = '{token: 4'd5, data: 32'h0, exception: 1'b0, cause: 4'd0};
        er = '{token: 4'd6, data: 32'h1234_5678, exception: 1'b0, cause: 4'd0};
        @(negedge clk_core);
        checks++;
        if (valid_o !== 1'b1 || result_o !== ew || pending_reads_down !== 1'b1) begin
            errors++;
            $display("FAIL order_first: got v=%b res=%h rdown=%b want v=1 res=%h rdown=1",
                     valid_o, result_o, pending_reads_down, ew);
        end
        step();
        idle_inputs();
        @(negedge clk_core);
        checks++;
        if (valid_o !== 1'b1 || result_o !== er) begin
            errors++; $display("FAIL order_second: got v=%b res=%h want v=1 res=%h", valid_o, result_o, er);
        end
        step();
    endtask

    // Two stores ahead of a fence, pending_writes starting at 2.
    task automatic test_fence();
        mem_meta_t   m[3];
        int          idx = 0, nobs = 0, fr_cyc = -1, zero_cyc = -1;
        int          obs_tok[3], obs_cyc[3];
        mem_result_t obs_res[3];
        logic        wd;
        m[0] = mk_meta(7, DIR_WRITE, WORD, 1'b0, 0, 1'b0, 1'b0);
        m[1] = mk_meta(8, DIR_WRITE, WORD, 1'b0, 0, 1'b0, 1'b0);
        m[2] = mk_meta(9, DIR_READ,  WORD, 1'b0, 0, 1'b0, 1'b1);
        idle_inputs();
        pending_writes = mem_counter'(2);
        for (int cyc = 0; cyc < 40 && nobs < 3; cyc++) begin
            meta_valid_i = (idx < 3);
            meta_i = (idx < 3) ? m[idx] : '0;
            dmem_b_valid = (idx < 2) && (cyc >= 3 + 3 * idx);
            @(negedge clk_core);
            if (cyc == 0) begin
                checks++;
                if (fence_ready !== 1'b0) begin
                    errors++; $display("FAIL fence_busy: got fence_ready=%b want 0", fence_ready);
                end
            end
            if (pending_writes == '0 && zero_cyc < 0) zero_cyc = cyc;
            if (valid_o === 1'b1) begin
                obs_tok[nobs] = int'(result_o.token); obs_cyc[nobs] = cyc; obs_res[nobs] = result_o; nobs++;
            end
            if (idx == 2 && fence_ready === 1'b1 && fr_cyc < 0) fr_cyc = cyc;
            wd = pending_writes_down;
            if (meta_valid_i && meta_ready_o) idx++;
            @(posedge clk_core);
            if (wd) pending_writes = pending_writes - 1'b1;
            #1;
        end
        idle_inputs();
        checks++;
        if (nobs != 3) begin
            errors++; $display("FAIL fence_timeout: got %0d results want 3", nobs);
        end else begin
            checks++;
            if (obs_tok[0] != 7 || obs_tok[1] != 8 || obs_tok[2] != 9) begin
                errors++; $display("FAIL fence_order: got %0d %0d %0d want 7 8 9", obs_tok[0], obs_tok[1], obs_tok[2]);
            end
            checks++;
            if (obs_res[2] !== '{token: 4'd9, data: 32'h0, exception: 1'b0, cause: 4'd0}) begin
                errors++; $display("FAIL fence_result: got %h want token 9 no exception", obs_res[2]);
            end
            checks++;
            if (fr_cyc < 0 || obs_cyc[2] != fr_cyc + 1 || zero_cyc < 0 || obs_cyc[2] <= zero_cyc) begin
                errors++;
                $display("FAIL fence_timing: got fence at %0d ready at %0d zero at %0d want ready+1 after zero",
                         obs_cyc[2], fr_cyc, zero_cyc);
            end
        end
        step();
    endtask

    // Result held under stall; nothing accepted meanwhile.
    task automatic test_stall();
        mem_result_t ea, eb;
        mem_meta_t   ma, mb;
        ma = mk_meta(10, DIR_READ, WORD, 1'b0, 0, 1'b0, 1'b0);
        mb = mk_meta(11, DIR_READ, BYTE, 1'b1, 1, 1'b0, 1'b0);
        ea = model_result(ma, 32'hCAFE_F00D, 2'b00);
        eb = model_result(mb, 32'h0102_0304, 2'b00);
        idle_inputs();
        meta_valid_i = 1'b1; meta_i = ma; dmem_r_valid = 1'b1; dmem_r_data = 32'hCAFE_F00D; stall_i = 1'b1;
        step();
        meta_i = mb; dmem_r_data = 32'h0102_0304;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk_core);
            checks++;
            if (valid_o !== 1'b1 || result_o !== ea ||
                {meta_ready_o, dmem_r_ready, dmem_b_ready, pending_reads_down, pending_writes_down} !== 5'b0) begin
                errors++;
                $display("FAIL stall_hold[%0d]: got v=%b res=%h ctrl=%b want v=1 res=%h ctrl=00000", c, valid_o, result_o,
                         {meta_ready_o, dmem_r_ready, dmem_b_ready, pending_reads_down, pending_writes_down}, ea);
            end
            step();
        end
        stall_i = 1'b0;
        @(negedge clk_core);
        checks++;
        if (dmem_r_ready !== 1'b1 || pending_reads_down !== 1'b1 || result_o !== ea) begin
            errors++;
            $display("FAIL stall_release: got r_ready=%b down=%b res=%h want 1 1 %h",
                     dmem_r_ready, pending_reads_down, result_o, ea);
        end
        step();
        idle_inputs();
        @(negedge clk_core);
        checks++;
        if (valid_o !== 1'b1 || result_o !== eb) begin
            errors++; $display("FAIL stall_next: got v=%b res=%h want v=1 res=%h", valid_o, result_o, eb);
        end
        step();
    endtask

    task automatic test_flush_drain();
        int   ndown = 0;
        logic rd, wd;
        // Flush with a same-cycle beat that retires the last read: counted, no result, stays RUN.
        idle_inputs();
        pending_reads = mem_counter'(1); pending_writes = '0;
        meta_valid_i = 1'b1; meta_i = mk_meta(12, DIR_READ, WORD, 1'b0, 0, 1'b0, 1'b0);
        dmem_r_valid = 1'b1; dmem_r_data = 32'h5555_AAAA; flush = 1'b1;
        @(negedge clk_core);
        checks++;
        if (pending_reads_down !== 1'b1 || meta_ready_o !== 1'b0) begin
            errors++; $display("FAIL flush_beat: got down=%b meta_ready=%b want 1 0", pending_reads_down, meta_ready_o);
        end
        @(posedge clk_core);
        pending_reads = '0;
        #1;
        idle_inputs();
        meta_valid_i = 1'b1; meta_i = mk_meta(13, DIR_WRITE, WORD, 1'b0, 0, 1'b0, 1'b0);
        @(negedge clk_core);
        checks++;
        if (valid_o !== 1'b0 || dmem_r_ready !== 1'b0 || dmem_b_ready !== 1'b1) begin
            errors++;
            $display("FAIL flush_no_result: got v=%b r_ready=%b b_ready=%b want 0 0 1", valid_o, dmem_r_ready, dmem_b_ready);
        end
        step();
        // Flush with 2 reads and 1 write outstanding.
        pending_reads = mem_counter'(2); pending_writes = mem_counter'(1);
        meta_i = mk_meta(14, DIR_READ, WORD, 1'b0, 0, 1'b1, 1'b0);
        flush = 1'b1;
        @(negedge clk_core);
        checks++;
        if (meta_ready_o !== 1'b0) begin
            errors++; $display("FAIL flush_meta_ready: got %b want 0", meta_ready_o);
        end
        step();
        flush = 1'b0;
        for (int cyc = 0; cyc < 5; cyc++) begin
            dmem_r_valid = (cyc == 0 || cyc == 4);
            dmem_b_valid = (cyc == 2);
            dmem_b_resp  = 2'b10;
            @(negedge clk_core);
            checks++;
            if (valid_o !== 1'b0 || meta_ready_o !== 1'b0 || dmem_r_ready !== 1'b1 || dmem_b_ready !== 1'b1 ||
                pending_reads_down !== dmem_r_valid || pending_writes_down !== dmem_b_valid) begin
                errors++;
                $display("FAIL drain[%0d]: got v=%b mr=%b rr=%b br=%b rd=%b wd=%b", cyc, valid_o, meta_ready_o,
                         dmem_r_ready, dmem_b_ready, pending_reads_down, pending_writes_down);
            end
            rd = pending_reads_down; wd = pending_writes_down;
            ndown += int'(rd) + int'(wd);
            @(posedge clk_core);
            if (rd) pending_reads = pending_reads - 1'b1;
            if (wd) pending_writes = pending_writes - 1'b1;
            #1;
        end
        dmem_r_valid = 1'b0; dmem_b_valid = 1'b0;
        @(negedge clk_core);
        checks++;
        if (ndown != 3 || meta_ready_o !== 1'b1 || dmem_r_ready !== 1'b0 || dmem_b_ready !== 1'b0) begin
            errors++;
            $display("FAIL drain_exit: got downs=%0d mr=%b rr=%b br=%b want 3 1 0 0",
                     ndown, meta_ready_o, dmem_r_ready, dmem_b_ready);
        end
        idle_inputs();
        step();
    endtask

    task automatic test_reset_mid_drain();
        idle_inputs();
        pending_reads = mem_counter'(1); pending_writes = '0;
        flush = 1'b1;
        step();
        flush = 1'b0;
        meta_valid_i = 1'b1; meta_i = mk_meta(3, DIR_READ, WORD, 1'b0, 0, 1'b0, 1'b0);
        dmem_r_valid = 1'b1;
        #1;
        rst_core_n = 1'b0;
        @(negedge clk_core);
        checks++;
        if ({valid_o, meta_ready_o, dmem_r_ready, dmem_b_ready, pending_reads_down, pending_writes_down} !== 6'b0 ||
            result_o !== '0) begin
            errors++;
            $display("FAIL reset_drain: got ctrl=%b res=%h want 000000 0",
                     {valid_o, meta_ready_o, dmem_r_ready, dmem_b_ready, pending_reads_down, pending_writes_down}, result_o);
        end
        @(posedge clk_core);
        #3;
        rst_core_n = 1'b1;
        dmem_r_valid = 1'b0; pending_reads = '0;
        meta_valid_i = 1'b0;
        step(); step();
        meta_valid_i = 1'b1; meta_i = mk_meta(4, DIR_WRITE, WORD, 1'b0, 0, 1'b0, 1'b0);
        @(negedge clk_core);
        checks++;
        if (dmem_r_ready !== 1'b0 || dmem_b_ready !== 1'b1) begin
            errors++; $display("FAIL reset_run: got rr=%b br=%b want 0 1", dmem_r_ready, dmem_b_ready);
        end
        idle_inputs();
        step();
    endtask

    // Random in-order stream with random stalls and beat delays.
    task automatic test_back_to_back();
        localparam int N = 200;
        mem_meta_t   list[N];
        int          idx = 0;
        logic        mvalid = 1'b0, r_on = 1'b0, b_on = 1'b0, free, acc, is_rd, is_wr, is_mis;
        mem_result_t mres = '0;
        logic [4:0]  exp_ctrl;
        for (int i = 0; i < N; i++)
            list[i] = mk_meta(int'($urandom_range(0, 15)), mem_dir_t'($urandom_range(0, 1)),
                              mem_size_t'($urandom_range(0, 2)), 1'($urandom_range(0, 1)),
                              int'($urandom_range(0, 3)), ($urandom_range(0, 7) == 0), 1'b0);
        idle_inputs();
        pending_reads = '0; pending_writes = '0;
        for (int cyc = 0; cyc < 3000 && (idx < N || mvalid); cyc++) begin
            meta_valid_i = (idx < N);
            meta_i = (idx < N) ? list[idx] : '0;
            is_mis = (idx < N) && list[idx].misaligned;
            is_rd  = (idx < N) && !is_mis && list[idx].dir == DIR_READ;
            is_wr  = (idx < N) && !is_mis && list[idx].dir == DIR_WRITE;
            if (is_rd && !r_on && $urandom_range(0, 9) < 6) begin
                r_on = 1'b1; dmem_r_data = $urandom; dmem_r_resp = ($urandom_range(0, 7) == 0) ? 2'b10 : 2'b00;
            end
            if (is_wr && !b_on && $urandom_range(0, 9) < 6) begin
                b_on = 1'b1; dmem_b_resp = ($urandom_range(0, 7) == 0) ? 2'b10 : 2'b00;
            end
            dmem_r_valid = r_on; dmem_b_valid = b_on;
            stall_i = ($urandom_range(0, 3) == 0);
            @(negedge clk_core);
            free = !mvalid || !stall_i;
            acc  = free && (is_mis || (is_rd && r_on) || (is_wr && b_on));
            exp_ctrl = {acc, is_rd && free, is_wr && free, acc && is_rd, acc && is_wr};
            checks++;
            if (valid_o !== mvalid || (mvalid && result_o !== mres)) begin
                errors++;
                $display("FAIL rand_result[%0d]: got v=%b res=%h want v=%b res=%h", cyc, valid_o, result_o, mvalid, mres);
            end
            checks++;
            if ({meta_ready_o, dmem_r_ready, dmem_b_ready, pending_reads_down, pending_writes_down} !== exp_ctrl) begin
                errors++;
                $display("FAIL rand_ctrl[%0d]: got %b want %b", cyc,
                         {meta_ready_o, dmem_r_ready, dmem_b_ready, pending_reads_down, pending_writes_down}, exp_ctrl);
            end
            @(posedge clk_core);
            if (acc) begin
                mvalid = 1'b1;
                mres = model_result(list[idx], dmem_r_data, is_rd ? dmem_r_resp : dmem_b_resp);
                idx++;
                r_on = 1'b0; b_on = 1'b0;
            end else if (!stall_i) begin
                mvalid = 1'b0;
            end
            #1;
        end
        checks++;
        if (idx != N) begin
            errors++; $display("FAIL rand_timeout: got %0d retired want %0d", idx, N);
        end
        idle_inputs();
        step();
    endtask

    initial begin
        test_reset();
        test_load_format();
        test_order();
        test_fence();
        test_stall();
        test_flush_drain();
        test_back_to_back();
        test_reset_mid_drain();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/hsv_core_mem_response.md
# hsv_core_mem_response

Response stage of the ScaleCore-V memory unit, directly downstream of the request stage. It consumes dmem R and B beats in program order against a per-instruction metadata stream, and formats load data (byte lane select, sign/zero extension). It retires pending-read/pending-write counter entries and drives the memory unit's result port toward commit. It also produces `fence_ready` for the request stage and drains outstanding AXI responses after a flush.

## Interface
- `PENDING_FIFO_DEPTH`, 8, depth of pending read/write FIFOs; sizes `mem_counter`.
- `clk_core` in 1: core clock.
- `rst_core_n` in 1: reset, asynchronous, active-low.
- `flush` in 1: pipeline flush (one-cycle pulse).
- `meta_i` in `mem_meta_t`: token, direction, size, unsigned, addr[1:0], misaligned, fence.
- `meta_valid_i` in 1 / `meta_ready_o` out 1: metadata handshake, one entry per memory instruction, in program order.
- `dmem_r_valid` in 1 / `dmem_r_ready` out 1 / `dmem_r_data` in 32 / `dmem_r_resp` in 2: AXI read data channel.
- `dmem_b_valid` in 1 / `dmem_b_ready` out 1 / `dmem_b_resp` in 2: AXI write response channel.
- `pending_reads`, `pending_writes` in `mem_counter`: current outstanding counts.
- `pending_reads_down`, `pending_writes_down` out 1: pop one entry from the matching pending FIFO.
- `fence_ready` out 1: all prior transactions are complete.
- `valid_o` out 1 / `stall_i` in 1: result handshake toward commit.
- `result_o` out `mem_result_t`: token, data word, exception, cause (load/store access fault or misaligned).

## Operation
- States: RUN, DRAIN. Reset state is RUN.
- RUN: the head metadata entry (`meta_valid_i`) selects the action. `out_free = ~valid_o | ~stall_i`.
  - misaligned: emit result with exception and cause misaligned load/store. No bus beat. Pop meta when `out_free`.
  - fence: emit result without exception when `fence_ready & out_free`, then pop meta.
  - read: `dmem_r_ready = out_free`. On R handshake, pop meta, pulse `pending_reads_down`, and emit a result.
    - data = `r_data >> (addr*8)`, then truncated to size.
    - Sign-extended unless unsigned.
    - `r_resp[1]=1` gives exception, load access fault, data 0.
  - write: `dmem_b_ready = out_free`. On B handshake, pop meta, pulse `pending_writes_down`, and emit a result with data 0.
    - `b_resp[1]=1` gives store access fault.
- Only the channel that matches the head entry is ever readied. A beat on the other channel waits with valid held, per AXI.
- `fence_ready = (pending_reads==0) & (pending_writes==0) & ~valid_o`. This is combinational.
- `flush`: `valid_o` is cleared next cycle and `meta_ready_o` drops (request-side meta FIFO is flushed by its owner).
  - If either pending count is nonzero, go to DRAIN.
- DRAIN: `dmem_r_ready=1`, `dmem_b_ready=1`.
  - Each handshake pulses the matching `_down` signal.
  - No results are emitted and metadata is ignored.
  - Return to RUN when both counts reach 0, including a count reaching 0 in the same cycle as the final handshake.
- `flush` during DRAIN keeps the block in DRAIN.

## Timing
- Reset values: `valid_o=0`, `result_o='0`, `meta_ready_o=0`, `dmem_r_ready=0`, `dmem_b_ready=0`, `_down=0`, state RUN.
- `meta_ready_o` and all readies are combinational from state, head meta and `out_free`. None depends on `dmem_*_valid`, so there is no AXI valid→ready loop.
- Latency is 1 cycle: an R/B handshake in cycle N gives `valid_o` in N+1. Misaligned and fence results likewise appear one cycle after the pop.
- Back-to-back results are allowed every cycle when `stall_i=0`.
- Under `stall_i=1` with `valid_o=1`, `result_o` holds stable and no new beat or meta is accepted.
- `_down` pulses are single-cycle and coincide with the handshake cycle.
- `flush` has priority over a same-cycle result: the beat is still accepted and counted down, but no result is emitted.

## Structure
- `hsv_core_pkg` holds:
  - `mem_meta_t` and `mem_result_t`.
  - Cause codes `EXC_LOAD_MISALIGNED`, `EXC_STORE_MISALIGNED`, `EXC_LOAD_FAULT`, `EXC_STORE_FAULT`.
  - `mem_size_t` (BYTE/HALF/WORD).
  - Existing `mem_counter` and `word`.
- One sub-module, `hsv_core_mem_load_align`: purely combinational lane shift, size truncation and sign extension. It is unit-testable on its own.
- Top module contains the FSM, handshake logic and output register. Target is about 200 RTL lines.

## Test plan
- LB, signed, addr[1:0]=3, `r_data=0x80AA_BBCC`, OKAY → `result.data=0xFFFF_FF80`, no exception, `pending_reads_down` pulse, `valid_o` next cycle.
- LHU at addr=2, `r_data=0x8001_1234` → data `0x0000_8001`. SW with `b_resp=SLVERR` → exception, `EXC_STORE_FAULT`.
- Head is write; R beat arrives first → `dmem_r_ready=0` until B completes. Then the read is accepted in program order and the results come out write then read.
- Fence with `pending_writes=2` → no result until both B beats retire and counts reach 0. Fence result follows one cycle after `fence_ready`.
- `stall_i` held 3 cycles with `valid_o=1` → `result_o` stable, both readies low, no `_down` pulses.
- Flush with 2 reads and 1 write outstanding → DRAIN.
  - Three beats are accepted with `_down` pulses and `valid_o` stays 0.
  - Return to RUN when counts reach 0. Mid-DRAIN `rst_core_n` low gives all outputs at reset values.
